// File: rtl/my_mux_if.sv
// my_mux_if: select, data and result bundle for my_mux
interface my_mux_if #(parameter int WIDTH = 1);
   logic             en;
   logic [2:0]       s;
   logic [WIDTH-1:0] i0, i1, i2, i3, i4, i5, i6;
   logic [WIDTH-1:0] y, y_q;
   logic             sel_err, err_sticky;
   modport master (output en, s, i0, i1, i2, i3, i4, i5, i6, input y, y_q, sel_err, err_sticky);
   modport slave (input en, s, i0, i1, i2, i3, i4, i5, i6, output y, y_q, sel_err, err_sticky);
endinterface

// File: rtl/my_mux.sv
// my_mux: 7:1 mux with out-of-range default, registered copy and select-error flags
module my_mux #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] OOR_VAL = '0
) (
   input logic     clk,
   input logic     rst,
   my_mux_if.slave bus
);
   logic [WIDTH-1:0] d [8];
   logic             oor;
   // slot 7 holds the out-of-range value so every s code indexes a known entry
   assign d = '{bus.i0, bus.i1, bus.i2, bus.i3, bus.i4, bus.i5, bus.i6, OOR_VAL};
   assign oor = bus.s == 3'd7;
   assign bus.y = d[bus.s];
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.y_q        <= '0;
         bus.sel_err    <= 1'b0;
         bus.err_sticky <= 1'b0;
      end else if (bus.en) begin
         bus.y_q        <= bus.y;
         bus.sel_err    <= oor;
         bus.err_sticky <= bus.err_sticky | oor;
      end
   end
endmodule

// File: tb/tb_my_mux.sv
// tb_my_mux: scoreboard bench for my_mux, WIDTH 4 with a non-zero out-of-range value
module tb_my_mux;
   localparam int         W   = 4;
   localparam logic [3:0] OOR = 4'hA;
   typedef struct {
      string      tag;
      int         sig;
      logic [3:0] exp;
   } exp_t;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] din [7];
   logic [3:0] m_yq;
   logic       m_se, m_es;
   exp_t       sb [$];
   int         n_cmp = 0;
   int         n_bad = 0;
   my_mux_if #(.WIDTH(W)) bus ();
   my_mux #(.WIDTH(W), .OOR_VAL(OOR)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic [3:0] model_y();
      return bus.s == 3'd7 ? OOR : din[bus.s];
   endfunction
   task automatic push(input string tag, input int sig, input logic [3:0] exp);
      sb.push_back('{tag, sig, exp});
   endtask
   task automatic drain();
      exp_t e;
      logic [3:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         obs = e.sig == 0 ? bus.y : e.sig == 1 ? bus.y_q : e.sig == 2 ? {3'b0, bus.sel_err} : {3'b0, bus.err_sticky};
         check(e.tag, obs, e.exp);
      end
   endtask
   task automatic apply();
      {bus.i0, bus.i1, bus.i2, bus.i3, bus.i4, bus.i5, bus.i6} = {din[0], din[1], din[2], din[3], din[4], din[5], din[6]};
   endtask
   task automatic comb(input string tag);
      apply();
      push(tag, 0, model_y());
      #1;
      drain();
   endtask
   task automatic tick(input string tag);
      if (rst) begin
         m_yq = '0;
         m_se = 1'b0;
         m_es = 1'b0;
      end else if (bus.en) begin
         m_yq = model_y();
         m_se = bus.s == 3'd7;
         m_es = m_es | m_se;
      end
      @(posedge clk);
      #1;
      push({tag, ".y_q"}, 1, m_yq);
      push({tag, ".sel_err"}, 2, {3'b0, m_se});
      push({tag, ".err_sticky"}, 3, {3'b0, m_es});
      drain();
   endtask
   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
   initial begin
      rst = 1'b1;
      bus.en = 1'b1;
      bus.s = 3'd1;
      for (int k = 0; k < 7; k++) din[k] = '0;
      din[1] = 4'h1;
      apply();
      tick("reset1");
      tick("reset2");
      comb("y_during_reset");
      rst = 1'b0;
      tick("capture_s1");
      for (int k = 0; k < 7; k++) din[k] = '0;
      for (int k = 0; k < 8; k++) begin
         bus.s = 3'(k);
         comb($sformatf("zeros_s%0d", k));
         #19;
      end
      for (int k = 0; k < 7; k++) din[k] = {3'b0, 1'(k % 2)};
      for (int k = 0; k < 8; k++) begin
         bus.s = 3'(k);
         comb($sformatf("alt_s%0d", k));
         #19;
      end
      for (int k = 0; k < 7; k++) din[k] = 4'(k * 3 + 2);
      for (int k = 0; k < 8; k++) begin
         bus.s = 3'(k);
         comb($sformatf("distinct_s%0d", k));
      end
      bus.s = 3'd3;
      din[3] = 4'hF;
      for (int k = 0; k < 4; k++) begin
         din[0] = ~din[0];
         din[2] = ~din[2];
         din[5] = ~din[5];
         comb($sformatf("unsel_toggle%0d", k));
      end
      for (int k = 0; k < 3; k++) begin
         din[3] = ~din[3];
         comb($sformatf("sel_toggle%0d", k));
      end
      bus.en = 1'b1;
      bus.s = 3'd7;
      tick("oor_capture");
      bus.s = 3'd2;
      tick("after_oor");
      tick("sticky_hold");
      bus.s = 3'd7;
      tick("oor_again");
      bus.en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.s = 3'(k * 2 + 1);
         din[k * 2 + 1] = 4'(k + 5);
         comb($sformatf("en0_y%0d", k));
         tick($sformatf("en0_hold%0d", k));
      end
      bus.en = 1'b1;
      bus.s = 3'd7;
      rst = 1'b1;
      tick("rst_priority");
      rst = 1'b0;
      bus.s = 3'd4;
      tick("post_reset_capture");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/my_mux.md
MY_MUX -- requirements
Module: my_mux

Interface
- REQ-001: Parameter WIDTH, default 1: bit width of each data input and of every data output.
- REQ-002: Parameter OOR_VAL, default 0: value driven on y when s selects no input (s = 7); WIDTH bits wide.
- REQ-003: Clocking and reset: one clock; reset is synchronous and active-high.
- REQ-004: clk  input  1  sole clock; all registers update on the rising edge.
- REQ-005: rst  input  1  synchronous active-high reset.
- REQ-006: en  input  1  capture enable for the registered outputs.
- REQ-007: s  input  3  select code; 0..6 pick i0..i6; 7 is out of range.
- REQ-008: i0 through i6  input  WIDTH each  data inputs 0..6.
- REQ-009: y  output  WIDTH  combinational mux output.
- REQ-010: y_q  output  WIDTH  registered copy of y.
- REQ-011: sel_err  output  1  registered flag: the last captured s was 7.
- REQ-012: err_sticky  output  1  registered sticky flag: s = 7 was captured at least once since reset.

Function
- REQ-013: y SHALL equal i<s> for s = 0..6, purely combinationally, with no clock dependency and zero cycles of latency.
- REQ-014: For s = 7, y SHALL equal OOR_VAL.
- REQ-015: y SHALL never be X or Z when s and i0..i6 are known values.
- REQ-016: Any change on s or on the selected input SHALL propagate to y in the same simulation time step.
- REQ-017: Changes on non-selected inputs SHALL NOT affect y.
- REQ-018: On a rising clk edge with rst = 0 and en = 1, the register update SHALL be:
  - y_q <= y
  - sel_err <= (s == 7)
  - err_sticky <= err_sticky | (s == 7)
- REQ-019: On a rising clk edge with rst = 0 and en = 0, y_q, sel_err and err_sticky SHALL hold their values.
- REQ-020: y_q, sel_err and err_sticky SHALL have a latency of exactly one clk edge relative to their inputs.
- REQ-021: err_sticky SHALL clear only on reset.
- REQ-022: The block SHALL contain no state machine; its only state is y_q, sel_err and err_sticky.
- REQ-023: WIDTH > 1 SHALL select all bits of the chosen input in parallel; bits SHALL NOT be mixed across inputs.

Reset
- REQ-024: While rst = 1 at a rising clk edge, regardless of en:
  - y_q <= 0
  - sel_err <= 0
  - err_sticky <= 0
- REQ-025: Reset SHALL NOT affect y; y stays combinational during reset.
- REQ-026: If rst and en are both 1 on the same edge, reset SHALL take priority.
- REQ-027: Before the first reset edge, register values are unspecified; the bench SHALL apply reset before checking them.

Verification
- REQ-028: Inputs all 0, s swept 0..7 -> y = 0 at every step.
- REQ-029: i0..i6 = 0,1,0,1,0,1,0 (WIDTH = 1), s stepped 0..7 with 20 ns per step -> y = 0,1,0,1,0,1,0,0 (the last value is OOR_VAL).
- REQ-030: s = 3, toggle i0, i2 and i5 while i3 is held at 1 -> y stays 1 throughout; then toggle i3 -> y follows i3 in the same time step.
- REQ-031: rst high for 2 edges, then en = 1, s = 1, i1 = 1 -> y_q = 0 during reset and y_q = 1 one edge after capture; sel_err = 0.
- REQ-032: en = 1, s = 7 for one edge, then s = 2 -> sel_err reads 1 then 0; err_sticky stays 1 until rst = 1 at an edge, then reads 0.
- REQ-033: en = 0 with s and inputs changing across 3 edges -> y_q, sel_err and err_sticky are unchanged while y tracks the inputs.
